nibble_addsub_seq: RTL and testbench
====================================

# nibble_addsub_seq

Multi-cycle sequencer that performs wide signed/unsigned add and subtract on the team's 4-bit add/sub datapath, one nibble per clock, LSB nibble first. It latches wide operands on a start handshake and drives the nibble datapath's A, B and carry-in each cycle. It captures the nibble sum and carry-out into a ripple carry register, then reports the wide result with carry/borrow, overflow and sign flags. It sits between a requester (control FSM or bench) and one shared combinational nibble adder.

## Interface
- NIBBLES, 4, operand width in nibbles; W = 4*NIBBLES (NIBBLES >= 2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- op  in  1  0 = A+B, 1 = A-B
- A_in  in  W  operand A, sampled on accept
- B_in  in  W  operand B, sampled on accept
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse, result valid
- Result  out  W  wide result, held until next accept
- Cout  out  1  carry (add) / borrow (sub, = ~carry)
- V  out  1  signed overflow
- Neg  out  1  true sign of signed result
- DP_A  out  4  nibble A to datapath
- DP_B  out  4  nibble B to datapath, pre-inverted when op=1
- DP_Cin  out  1  datapath carry-in
- DP_Sum  in  4  datapath sum (combinational from DP_*)
- DP_Cout  in  1  datapath carry-out

## Operation
- States: IDLE, RUN, [ABS], DONE.
- IDLE: ready=1. On start=1: latch A_in, B_in, op; clear idx to 0; go to RUN. start while not IDLE is ignored (not queued).
- RUN: DP_A = A_reg[4*idx+:4]; DP_B = B_reg[4*idx+:4] ^ {4{op}}; DP_Cin = op when idx=0, else carry_reg. Each edge: Result[4*idx+:4] <= DP_Sum, carry_reg <= DP_Cout, idx++. After the edge with idx = NIBBLES-1: go to ABS if compiled, else DONE.
- On the last nibble, also register V = (A_msb == B'_msb) & (DP_Sum[3] != A_msb), where B'_msb is the inverted MSB for sub. Register Cout = DP_Cout ^ op and Neg = DP_Sum[3] ^ V.
- DONE: done=1 for exactly one cycle, then IDLE. Result/Cout/V/Neg hold until the next accept.
- Outside RUN: DP_A, DP_B and DP_Cin = 0.
- Arithmetic is mod 2^W two's complement. The subtract result is raw two's complement unless ABS is compiled in.

## Timing
- Reset (async, any state): state=IDLE, idx=0, carry_reg=0, Result=0, Cout=0, V=0, Neg=0, done=0, ready=1, DP_* = 0. An operation in flight is discarded with no done pulse.
- Accept at edge k. Nibble i is captured at edge k+1+i. done is high in the cycle after edge k+NIBBLES (+1 if ABS).
- Latency from accept to done: NIBBLES+1 cycles (NIBBLES+2 with ABS). Issue interval is NIBBLES+2 (NIBBLES+3) cycles; ready returns high the cycle after done.
- start held high continuously produces back-to-back operations at the issue interval, re-sampling the operands each time.
- DP_Sum/DP_Cout must settle within one cycle of DP_* changing; there is no pipeline in the datapath path.

## Configuration
- ADDSUB_ABS_EN defined: adds ABS state (one cycle). If Neg=1, Result <= ~Result + 1 (magnitude, unsigned W bits; correct for overflow cases too). Otherwise Result is unchanged. This applies to both add and sub, and Neg keeps the sign.
- Undefined: no ABS state, and Result is the raw two's complement value.

## Test plan
- NIBBLES=4, add 0x1234+0x0FCD -> done at accept+5 cycles, Result=0x2201, Cout=0, V=0, Neg=0.
- Add 0xFFFF+0x0001 -> Result=0x0000, Cout=1, V=0. Add 0x7FFF+0x0001 -> Result=0x8000, V=1, Cout=0, Neg=0.
- Sub 0x0005-0x0007 -> Result=0xFFFE (0x0002 with ADDSUB_ABS_EN), Cout=1 (borrow), V=0, Neg=1.
- Sub 0x8000-0x0001 -> Result=0x7FFF (0x8001 with ADDSUB_ABS_EN), V=1, Cout=0, Neg=1.
- Pulse start with new operands during RUN -> ignored; first result is unchanged and exactly one done is produced. Back-to-back start -> second done exactly NIBBLES+2 cycles after the first.
- Drop rst_n during RUN at idx=2 -> all outputs return to reset values immediately, no done, ready=1. The next operation completes correctly.

Source files
------------

// File: rtl/nibble_addsub_seq_if.sv
// -----------------------------------------------------------------------------
// nibble_addsub_seq_if
//   Bundles the requester handshake, the wide result/flags and the link to the
//   shared 4-bit combinational add/sub datapath.
//
//   Parameter NIBBLES : operand width in nibbles (W = 4*NIBBLES)
//
//   Requester side : start, op, A_in, B_in  -> sequencer
//                    ready, done, Result, Cout, V, Neg <- sequencer
//   Datapath side  : DP_A, DP_B, DP_Cin      <- sequencer
//                    DP_Sum, DP_Cout         -> sequencer
//
//   modport slave  : the sequencer
//   modport master : the requester, which also hosts the nibble adder
// -----------------------------------------------------------------------------
interface nibble_addsub_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         op;
  logic [W-1:0] A_in;
  logic [W-1:0] B_in;
  logic         ready;
  logic         done;
  logic [W-1:0] Result;
  logic         Cout;
  logic         V;
  logic         Neg;
  logic [3:0]   DP_A;
  logic [3:0]   DP_B;
  logic         DP_Cin;
  logic [3:0]   DP_Sum;
  logic         DP_Cout;

  modport slave (
    input  start, op, A_in, B_in, DP_Sum, DP_Cout,
    output ready, done, Result, Cout, V, Neg, DP_A, DP_B, DP_Cin
  );

  modport master (
    output start, op, A_in, B_in, DP_Sum, DP_Cout,
    input  ready, done, Result, Cout, V, Neg, DP_A, DP_B, DP_Cin
  );
endinterface

// File: rtl/nibble_addsub_seq.sv
// -----------------------------------------------------------------------------
// nibble_addsub_seq
//   Wide signed/unsigned add/subtract sequenced over a shared 4-bit
//   combinational adder, one nibble per clock, LSB nibble first.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : nibble_addsub_seq_if.slave
//             start/op/A_in/B_in in, ready/done/Result/Cout/V/Neg out,
//             DP_A/DP_B/DP_Cin out to the nibble adder, DP_Sum/DP_Cout back.
//
//   Optional feature macro: ADDSUB_ABS_EN
//     When defined, an extra ABS cycle replaces a negative result with its
//     magnitude (~Result + 1); Neg still reports the true sign.
// -----------------------------------------------------------------------------
module nibble_addsub_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_addsub_seq_if.slave   bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ABS  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_r, state_s;
  logic [IW-1:0]  idx_r;
  logic [W-1:0]   a_r, b_r, result_r;
  logic           op_r, carry_r;
  logic           cout_r, v_r, neg_r;
  logic           ready_r, done_r;
  logic [3:0]     dp_a_s, dp_b_s;
  logic           dp_cin_s, v_s;

  // Signed overflow: operands agree in sign but the sum sign differs.
  function automatic logic ovf(input logic a_msb, input logic b_msb,
                               input logic sum_msb);
    return (a_msb == b_msb) & (sum_msb != a_msb);
  endfunction

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = RUN;
        else           state_s = IDLE;
      end
      RUN: begin
        if (idx_r == IDX_LAST) begin
`ifdef ADDSUB_ABS_EN
          state_s = ABS;
`else
          state_s = DONE;
`endif
        end else begin
          state_s = RUN;
        end
      end
`ifdef ADDSUB_ABS_EN
      ABS:     state_s = DONE;
`else
      ABS:     state_s = IDLE;
`endif
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath drive: only RUN presents operands; B is inverted for subtract so
  // the adder computes A + ~B + 1 with the +1 entering as the first carry-in.
  always_comb begin
    dp_a_s   = 4'd0;
    dp_b_s   = 4'd0;
    dp_cin_s = 1'b0;
    if (state_r == RUN) begin
      dp_a_s   = a_r[4*idx_r +: 4];
      dp_b_s   = b_r[4*idx_r +: 4] ^ {4{op_r}};
      dp_cin_s = (idx_r == '0) ? op_r : carry_r;
    end else begin
      dp_a_s   = 4'd0;
      dp_b_s   = 4'd0;
      dp_cin_s = 1'b0;
    end
    v_s = ovf(a_r[W-1], b_r[W-1] ^ op_r, bus.DP_Sum[3]);
  end

  // State register with registered ready/done decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  // Operand capture, nibble accumulation and final flag registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r    <= '0;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      op_r     <= 1'b0;
      carry_r  <= 1'b0;
      result_r <= {W{1'b0}};
      cout_r   <= 1'b0;
      v_r      <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_r   <= bus.A_in;
            b_r   <= bus.B_in;
            op_r  <= bus.op;
            idx_r <= '0;
          end
        end
        RUN: begin
          result_r[4*idx_r +: 4] <= bus.DP_Sum;
          carry_r <= bus.DP_Cout;
          idx_r   <= idx_r + IW'(1);
          if (idx_r == IDX_LAST) begin
            v_r    <= v_s;
            // Subtract reports borrow, which is the inverse of the carry.
            cout_r <= bus.DP_Cout ^ op_r;
            // Sum MSB is the sign unless overflow flipped it.
            neg_r  <= bus.DP_Sum[3] ^ v_s;
          end
        end
        ABS: begin
`ifdef ADDSUB_ABS_EN
          if (neg_r) result_r <= ~result_r + W'(1);
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.ready  = ready_r;
  assign bus.done   = done_r;
  assign bus.Result = result_r;
  assign bus.Cout   = cout_r;
  assign bus.V      = v_r;
  assign bus.Neg    = neg_r;
  assign bus.DP_A   = dp_a_s;
  assign bus.DP_B   = dp_b_s;
  assign bus.DP_Cin = dp_cin_s;
endmodule

// File: tb/tb_nibble_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_nibble_addsub_seq
//   Hosts the 4-bit nibble adder, drives directed operations and compares the
//   sequencer against a cycle-level behavioural model built from plain wide
//   arithmetic. Honours ADDSUB_ABS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_nibble_addsub_seq;
  localparam int N = 4;
  localparam int W = 4 * N;
`ifdef ADDSUB_ABS_EN
  localparam int ABS_CYC = 1;
  localparam logic [W-1:0] SUB1_RES = 16'h0002;
  localparam logic [W-1:0] SUB2_RES = 16'h8001;
`else
  localparam int ABS_CYC = 0;
  localparam logic [W-1:0] SUB1_RES = 16'hFFFE;
  localparam logic [W-1:0] SUB2_RES = 16'h7FFF;
`endif
  // Model count value during the done cycle.
  localparam int DLAST = N + 1 + ABS_CYC;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         op    = 1'b0;
  logic [W-1:0] a_in  = '0;
  logic [W-1:0] b_in  = '0;

  nibble_addsub_seq_if #(.NIBBLES(N)) bus();

  assign bus.start = start;
  assign bus.op    = op;
  assign bus.A_in  = a_in;
  assign bus.B_in  = b_in;
  // The shared combinational nibble adder.
  assign {bus.DP_Cout, bus.DP_Sum} = {1'b0, bus.DP_A} + {1'b0, bus.DP_B}
                                   + {4'b0000, bus.DP_Cin};

  nibble_addsub_seq #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Wide result from exact integer arithmetic.
  function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic o, output logic [W-1:0] r,
                               output logic c, output logic v, output logic n);
    int ea, eb, ex;
    ea = int'($signed(a));
    eb = int'($signed(b));
    ex = o ? (ea - eb) : (ea + eb);
    r  = W'(ex);
    c  = o ? (a < b) : ((int'(a) + int'(b)) >= (1 << W));
    v  = (ex >= (1 << (W - 1))) || (ex < -(1 << (W - 1)));
    n  = (ex < 0);
    if (ABS_CYC == 1 && n) r = -r;
  endfunction

  // ---- model: cnt 0 = idle, 1..N = nibble cycles, DLAST = done cycle ----
  int           cnt   = 0;
  logic [W-1:0] ma    = '0;
  logic [W-1:0] mb    = '0;
  logic         mop   = 1'b0;
  logic [W-1:0] h_res = '0;
  logic         h_c   = 1'b0;
  logic         h_v   = 1'b0;
  logic         h_n   = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [W-1:0] r;
    logic c, v, n;
    if (!rst_n) begin
      cnt <= 0; h_res <= '0; h_c <= 1'b0; h_v <= 1'b0; h_n <= 1'b0;
    end else if (cnt == 0) begin
      if (start) begin
        cnt <= 1; ma <= a_in; mb <= b_in; mop <= op;
      end
    end else if (cnt == DLAST - 1) begin
      calc(ma, mb, mop, r, c, v, n);
      h_res <= r; h_c <= c; h_v <= v; h_n <= n;
      cnt <= DLAST;
    end else if (cnt == DLAST) begin
      cnt <= 0;
    end else begin
      cnt <= cnt + 1;
    end
  end

  // ---- handshake between stimulus and the compare process ----
  int           lit_req = 0;
  int           lit_ack = 0;
  logic [W-1:0] lit_res = '0;
  logic         lit_c = 1'b0, lit_v = 1'b0, lit_n = 1'b0;
  int           tmo_hits = 0;
  int           tmo_seen = 0;
  bit           b2b_mode = 1'b0;
  bit           prev_b2b = 1'b0;
  int           cyc = 0;
  int           prev_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [3:0]   e_a, e_b;
    logic         e_cin;
    logic [W-1:0] bp;
    int           i, m, lows;
    cyc++;
    chk("ready", bus.ready, cnt == 0);
    chk("done", bus.done, cnt == DLAST);
    if (cnt == 0 || cnt == DLAST) begin
      chk("result", bus.Result, h_res);
      chk("cout", bus.Cout, h_c);
      chk("v", bus.V, h_v);
      chk("neg", bus.Neg, h_n);
    end
    e_a = 4'd0; e_b = 4'd0; e_cin = 1'b0;
    if (cnt >= 1 && cnt <= N) begin
      i     = cnt - 1;
      bp    = mop ? ~mb : mb;
      e_a   = ma[4*i +: 4];
      e_b   = bp[4*i +: 4];
      m     = (1 << (4 * i)) - 1;
      lows  = (int'(ma) & m) + (int'(bp) & m) + int'(mop);
      e_cin = lows[4*i];
    end
    chk("dp_a", bus.DP_A, e_a);
    chk("dp_b", bus.DP_B, e_b);
    chk("dp_cin", bus.DP_Cin, e_cin);
    if (bus.done && lit_req != lit_ack) begin
      chk("lit_result", bus.Result, lit_res);
      chk("lit_cout", bus.Cout, lit_c);
      chk("lit_v", bus.V, lit_v);
      chk("lit_neg", bus.Neg, lit_n);
      lit_ack = lit_req;
    end
    if (bus.done) begin
      if (b2b_mode && prev_b2b) chk("b2b_gap", cyc - prev_cyc, N + 2 + ABS_CYC);
      prev_b2b = b2b_mode;
      prev_cyc = cyc;
    end
    if (tmo_hits != tmo_seen) begin
      chk("timeout", tmo_hits, tmo_seen);
      tmo_seen = tmo_hits;
    end
  end

  // ---- stimulus helpers ----
  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!bus.ready && k < 40) begin @(negedge clk); k++; end
    if (!bus.ready) tmo_hits++;
  endtask

  task automatic wait_done();
    int k = 0;
    @(negedge clk);
    while (!bus.done && k < 40) begin @(negedge clk); k++; end
    if (!bus.done) tmo_hits++;
  endtask

  task automatic set_lit(input logic [W-1:0] r, input logic c, input logic v,
                         input logic n);
    lit_res = r; lit_c = c; lit_v = v; lit_n = n;
    lit_req++;
  endtask

  task automatic launch(input logic o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    @(posedge clk); #1;
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_op(input logic o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] r,
                       input logic c, input logic v, input logic n);
    wait_ready();
    set_lit(r, c, v, n);
    launch(o, a, b);
    wait_done();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #15 rst_n = 1'b1;

    do_op(1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op(1'b1, 16'h0005, 16'h0007, SUB1_RES, 1'b1, 1'b0, 1'b1);
    do_op(1'b1, 16'h8000, 16'h0001, SUB2_RES, 1'b0, 1'b1, 1'b1);
    do_op(1'b1, 16'h1000, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1);

    // start pulsed with new operands during RUN must be ignored
    wait_ready();
    set_lit(16'h0033, 1'b0, 1'b0, 1'b0);
    launch(1'b0, 16'h0011, 16'h0022);
    @(posedge clk); #1;
    op = 1'b1; a_in = 16'hAAAA; b_in = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);

    // start held high: back-to-back operations, operands re-sampled
    wait_ready();
    b2b_mode = 1'b1;
    @(posedge clk); #1;
    op = 1'b0; a_in = 16'h0100; b_in = 16'h0200; start = 1'b1;
    @(posedge clk); #1;
    op = 1'b1; a_in = 16'h4000; b_in = 16'h0001;
    wait_done();
    wait_done();
    start = 1'b0;
    wait_ready();
    b2b_mode = 1'b0;

    // asynchronous reset while idx = 2; no done may follow
    wait_ready();
    launch(1'b0, 16'h1111, 16'h2222);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;
    do_op(1'b0, 16'h0ABC, 16'h0123, 16'h0BDF, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
